apb_cmd_master: RTL and testbench

//  Converts a valid/ready command stream (one register read/write at a time) into APB3 transfers.
//  It is the APB master sitting directly upstream of the generated register blocks
//  (12-bit paddr, 32-bit data, pready/pslverr).

---
 rtl/apb_cmd_master_pkg.sv | 20 ++
 rtl/apb_cmd_master.sv | 139 +++++++++++++
 tb/tb_apb_cmd_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM state encoding and the response record
// returned to the host.
package apb_cmd_master_pkg;

    localparam int RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 master: turns one valid/ready register command at a time into an APB transfer,
// bounds the ACCESS phase with a pready timeout and returns the result on a response channel.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // A TIMEOUT of 0 disables the abort, but the counter keeps a 1-bit floor width.
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_t              rsp_q, rsp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a completion on the abort cycle still wins.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.rdata   = (!pwrite_q && !pslverr) ? RSP_DATA_W'(prdata) : '0;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a small APB register-block model with programmable wait
// states, plus a response scoreboard filled when a command is accepted.
module tb_apb_cmd_master;
    import apb_cmd_master_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Slave: 16 words at 0x000-0x03C, everything else answers with pslverr.
    logic [31:0] slv_mem [16];
    int          slv_acc = 0;
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic        slv_mapped;

    assign slv_mapped = (paddr < 12'h040);
    assign pready     = psel && penable && !slv_hang && (slv_acc >= slv_wait);
    assign pslverr    = pready && !slv_mapped;
    assign prdata     = slv_mapped ? slv_mem[paddr[5:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (psel && penable && !pready) slv_acc <= slv_acc + 1;
        else                            slv_acc <= 0;
        if (psel && penable && pready && pwrite && slv_mapped) slv_mem[paddr[5:2]] <= pwdata;
    end

    logic [31:0] model [16];
    rsp_t        exp_q [$];
    logic [11:0] last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected response for a command, decided from the bench's own view of the slave.
    task automatic predict(input logic wr, input logic [11:0] a, input logic [31:0] d);
        rsp_t e;
        e = '0;
        if (slv_hang) begin
            e.err = 1'b1;
            e.timeout = 1'b1;
        end else if (a >= 12'h040) begin
            e.err = 1'b1;
        end else if (wr) begin
            model[a[5:2]] = d;
        end else begin
            e.rdata = model[a[5:2]];
        end
        exp_q.push_back(e);
        last_addr = a;
    endtask

    task automatic start_cmd(input logic wr, input logic [11:0] a, input logic [31:0] d,
                             output int acc);
        int cyc;
        acc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        check("req_ready", req_ready, 1);
        predict(wr, a, d);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            if (psel && penable) acc++;
            @(negedge clk);
            cyc++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
    endtask

    task automatic finish_rsp(input int hold);
        rsp_t        e;
        logic [31:0] r0;
        r0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, r0);
        end
        rsp_ready = 1'b1;
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
            check("rsp_timeout", rsp_timeout, e.timeout);
            $display("rsp addr=%03h rdata=%08h err=%0d timeout=%0d", last_addr, rsp_rdata,
                     rsp_err, rsp_timeout);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_clr", rsp_valid, 0);
    endtask

    initial begin
        int acc;
        int cyc;
        logic [31:0] rnd;

        // Reset state
        #12;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);

        // 1: write with cycle-accurate phase checks
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h004; req_wdata = 32'hA5A5_0001;
        check("t1_accept", req_ready, 1);
        predict(1'b1, 12'h004, 32'hA5A5_0001);
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_setup_psel", psel, 1);
        check("t1_setup_penable", penable, 0);
        check("t1_setup_pwrite", pwrite, 1);
        check("t1_setup_paddr", paddr, 32'h004);
        check("t1_setup_pwdata", pwdata, 32'hA5A5_0001);
        check("t1_busy", req_ready, 0);
        @(negedge clk);
        check("t1_access_psel", psel, 1);
        check("t1_access_penable", penable, 1);
        check("t1_access_pwdata", pwdata, 32'hA5A5_0001);
        @(negedge clk);
        check("t1_resp_valid", rsp_valid, 1);
        check("t1_resp_psel", psel, 0);
        check("t1_resp_penable", penable, 0);
        check("t1_resp_pwdata", pwdata, 32'hA5A5_0001);
        check("t1_resp_paddr", paddr, 32'h004);
        finish_rsp(0);

        // 2: read back, plus a waited write/read pair
        start_cmd(1'b0, 12'h004, 32'h0, acc);
        finish_rsp(0);
        rnd = $urandom;
        slv_wait = 3;
        start_cmd(1'b1, 12'h010, rnd, acc);
        check("t2_wait_acc", acc, 4);
        finish_rsp(0);
        slv_wait = 2;
        start_cmd(1'b0, 12'h010, 32'h0, acc);
        finish_rsp(3);
        slv_wait = 0;

        // 3: unmapped read and write
        start_cmd(1'b0, 12'h800, 32'h0, acc);
        finish_rsp(0);
        start_cmd(1'b1, 12'h800, 32'h1234_5678, acc);
        finish_rsp(0);

        // 4: hung slave aborts after TIMEOUT access cycles; write must not land
        slv_hang = 1'b1;
        start_cmd(1'b0, 12'h008, 32'h0, acc);
        check("t4_rd_acc", acc, TIMEOUT);
        finish_rsp(1);
        start_cmd(1'b1, 12'h004, 32'h0000_1234, acc);
        check("t4_wr_acc", acc, TIMEOUT);
        finish_rsp(0);
        slv_hang = 1'b0;
        start_cmd(1'b0, 12'h004, 32'h0, acc);
        finish_rsp(0);

        // 4b: pready on the last allowed cycle completes normally
        slv_wait = TIMEOUT - 1;
        start_cmd(1'b0, 12'h004, 32'h0, acc);
        check("t4b_acc", acc, TIMEOUT);
        finish_rsp(0);
        slv_wait = TIMEOUT - 2;
        start_cmd(1'b0, 12'h010, 32'h0, acc);
        check("t4b_acc_m1", acc, TIMEOUT - 1);
        finish_rsp(0);
        slv_wait = 0;

        // 5: stalled response blocks a waiting command
        start_cmd(1'b0, 12'h004, 32'h0, acc);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h00C; req_wdata = 32'h0BAD_F00D;
        rnd = rsp_rdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_req_ready", req_ready, 0);
            check("t5_psel", psel, 0);
            check("t5_rsp_valid", rsp_valid, 1);
            check("t5_rsp_rdata", rsp_rdata, rnd);
        end
        finish_rsp(0);
        check("t5_accept", req_ready, 1);
        predict(1'b1, 12'h00C, 32'h0BAD_F00D);
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_next_psel", psel, 1);
        check("t5_next_paddr", paddr, 32'h00C);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("t5_rsp_wait", rsp_valid, 1);
        finish_rsp(0);

        // 6: reset asserted during ACCESS
        slv_hang = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h004;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!penable && cyc < 10) begin @(negedge clk); cyc++; end
        check("t6_in_access", penable, 1);
        #2 rst_b = 1'b0;
        #1;
        check("t6_psel_async", psel, 0);
        check("t6_penable_async", penable, 0);
        slv_hang = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_no_rsp", rsp_valid, 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("t6_req_ready", req_ready, 1);
        check("t6_no_rsp_after", rsp_valid, 0);
        start_cmd(1'b0, 12'h00C, 32'h0, acc);
        finish_rsp(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
